ip_tx_arbiter: RTL and testbench

//  Shares the single ip_packet_tx engine between NUM_REQ requesters, e.g. the LB-response path and the inference-result path.

---
 rtl/ip_tx_arb_pkg.sv | 23 ++
 rtl/ip_tx_rr_pick.sv | 42 ++++
 rtl/ip_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_ip_tx_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_arb_pkg.sv
// Shared types and widths for the ip_packet_tx arbiter.
//   IP_ADDR_W / MAC_ADDR_W / MSG_W : descriptor field widths
//   arb_state_t                    : arbiter FSM state encoding
//   descriptor_t                   : one latched transmit descriptor
package ip_tx_arb_pkg;

    localparam int unsigned IP_ADDR_W  = 32;
    localparam int unsigned MAC_ADDR_W = 48;
    localparam int unsigned MSG_W      = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [IP_ADDR_W-1:0]  ip;
        logic [MAC_ADDR_W-1:0] mac;
        logic [MSG_W-1:0]      msg;
    } descriptor_t;

endpackage

// File: rtl/ip_tx_rr_pick.sv
// Combinational round-robin selector.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   grant_o : one-hot winner (all 0 when no request)
//   idx_o   : binary index of the winner
//   any_o   : at least one request present
module ip_tx_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk ptr, ptr+1, ... modulo NUM_REQ; the first set request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one ip_packet_tx engine between NUM_REQ requesters.
// Accepts one descriptor per transaction, drives RECIPIENT_* / START_IP_TXN and
// watches TX_READY_FOR_SEND for engine accept and completion.
//   ACLK, ARESET (async, active-low)
//   REQ_VALID/REQ_READY, REQ_IP_ADDRESS/REQ_MAC_ADDRESS/REQ_MESSAGE : requester side
//   REQ_DONE  : completion pulse to the owner
//   BUSY      : FSM not idle
//   RECIPIENT_*, START_IP_TXN, TX_READY_FOR_SEND : engine side
//   TX_COUNT  : saturating per-requester packet counters, only when
//               IP_TX_ARB_STATS_EN is defined
module ip_tx_arbiter
    import ip_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ*IP_ADDR_W-1:0]  REQ_IP_ADDRESS,
    input  logic [NUM_REQ*MAC_ADDR_W-1:0] REQ_MAC_ADDRESS,
    input  logic [NUM_REQ*MSG_W-1:0]      REQ_MESSAGE,
    output logic [NUM_REQ-1:0]            REQ_DONE,
    output logic [IP_ADDR_W-1:0]          RECIPIENT_IP_ADDRESS,
    output logic [MAC_ADDR_W-1:0]         RECIPIENT_MAC_ADDRESS,
    output logic [MSG_W-1:0]              RECIPIENT_MESSAGE,
    output logic                          START_IP_TXN,
    input  logic                          TX_READY_FOR_SEND,
    output logic                          BUSY
`ifdef IP_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0] TX_COUNT
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    descriptor_t      desc_q, desc_d;
    logic             start_q, start_d;

    descriptor_t          req_desc [NUM_REQ];
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 grant_ok;
    logic                 done_fire;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_desc[g] = '{
            ip:  REQ_IP_ADDRESS[IP_ADDR_W*g +: IP_ADDR_W],
            mac: REQ_MAC_ADDRESS[MAC_ADDR_W*g +: MAC_ADDR_W],
            msg: REQ_MESSAGE[MSG_W*g +: MSG_W]
        };
    end

    ip_tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (REQ_VALID),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // ARESET gates the combinational ready so every output is 0 while in reset.
    assign grant_ok  = (state_q == IDLE) && TX_READY_FOR_SEND && pick_any && ARESET;
    assign REQ_READY = grant_ok ? pick_grant : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        desc_d    = desc_q;
        start_d   = start_q;
        done_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    desc_d  = req_desc[pick_idx];
                    owner_d = pick_idx;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                // Hold the start request until the engine shows it has taken it.
                if (!TX_READY_FOR_SEND) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (TX_READY_FOR_SEND) begin
                    done_fire = 1'b1;
                    rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            desc_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            desc_q   <= desc_d;
            start_q  <= start_d;
        end
    end

    always_comb begin
        REQ_DONE = '0;
        if (done_fire) begin
            REQ_DONE[owner_q] = 1'b1;
        end
    end

    assign RECIPIENT_IP_ADDRESS  = desc_q.ip;
    assign RECIPIENT_MAC_ADDRESS = desc_q.mac;
    assign RECIPIENT_MESSAGE     = desc_q.msg;
    assign START_IP_TXN          = start_q;
    assign BUSY                  = (state_q != IDLE);

`ifdef IP_TX_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [STAT_WIDTH-1:0] cnt_q;

        // Saturating: stops at all-ones instead of wrapping.
        always_ff @(posedge ACLK or negedge ARESET) begin
            if (!ARESET) begin
                cnt_q <= '0;
            end else if (REQ_DONE[g] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign TX_COUNT[STAT_WIDTH*g +: STAT_WIDTH] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_ip_tx_arbiter.sv
module tb_ip_tx_arbiter;

    localparam int N = 2;
`ifdef IP_TX_ARB_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_ip;
    logic [N*48-1:0] req_mac;
    logic [N*10-1:0] req_msg;
    logic [N-1:0]    req_done;
    logic [31:0]     rcp_ip;
    logic [47:0]     rcp_mac;
    logic [9:0]      rcp_msg;
    logic            start_txn;
    logic            tx_ready;
    logic            busy;
`ifdef IP_TX_ARB_STATS_EN
    logic [N*SW-1:0] tx_count;
`endif

    logic [31:0] d_ip  [N];
    logic [47:0] d_mac [N];
    logic [9:0]  d_msg [N];

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign req_ip[32*g +: 32]  = d_ip[g];
        assign req_mac[48*g +: 48] = d_mac[g];
        assign req_msg[10*g +: 10] = d_msg[g];
    end

    ip_tx_arbiter #(
        .NUM_REQ    (N),
        .STAT_WIDTH (SW)
    ) dut (
        .ACLK                  (clk),
        .ARESET                (rst_n),
        .REQ_VALID             (req_valid),
        .REQ_READY             (req_ready),
        .REQ_IP_ADDRESS        (req_ip),
        .REQ_MAC_ADDRESS       (req_mac),
        .REQ_MESSAGE           (req_msg),
        .REQ_DONE              (req_done),
        .RECIPIENT_IP_ADDRESS  (rcp_ip),
        .RECIPIENT_MAC_ADDRESS (rcp_mac),
        .RECIPIENT_MESSAGE     (rcp_msg),
        .START_IP_TXN          (start_txn),
        .TX_READY_FOR_SEND     (tx_ready),
        .BUSY                  (busy)
`ifdef IP_TX_ARB_STATS_EN
        ,
        .TX_COUNT              (tx_count)
`endif
    );

    // ip_packet_tx model: ready drops on the eng_lat-th edge that sees start,
    // stays low ~60 cycles, then returns.
    logic eng_ready;
    logic force_low = 1'b0;
    int   eng_lat   = 1;
    int   eng_seen;
    int   eng_cnt;
    int   eng_txns  = 0;

    assign tx_ready = eng_ready && !force_low;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready <= 1'b1;
            eng_seen  <= 0;
            eng_cnt   <= 0;
        end else if (eng_ready) begin
            if (start_txn && !force_low) begin
                if (eng_seen + 1 >= eng_lat) begin
                    eng_ready <= 1'b0;
                    eng_cnt   <= 60;
                    eng_seen  <= 0;
                    eng_txns  <= eng_txns + 1;
                end else begin
                    eng_seen <= eng_seen + 1;
                end
            end else begin
                eng_seen <= 0;
            end
        end else begin
            if (eng_cnt <= 1) eng_ready <= 1'b1;
            else eng_cnt <= eng_cnt - 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        oh_idx = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) oh_idx = i;
    endfunction

    // Scoreboard queues filled by stimulus, drained by the monitor.
    int exp_grant_q[$];
    int exp_done_q[$];
    int grants_seen = 0;
    int dones_seen  = 0;
    int last_start_w = 0;

    initial begin : monitor
        int   g;
        int   e;
        int   chk_idx;
        logic chk_next;
        int   start_run;
        chk_next  = 1'b0;
        start_run = 0;
        chk_idx   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_next  = 1'b0;
                start_run = 0;
            end else begin
                if (chk_next) begin
                    chk("recipient_ip", 64'(rcp_ip), 64'(d_ip[chk_idx]));
                    chk("recipient_mac", 64'(rcp_mac), 64'(d_mac[chk_idx]));
                    chk("recipient_msg", 64'(rcp_msg), 64'(d_msg[chk_idx]));
                    chk("start_after_grant", 64'(start_txn), 64'd1);
                    chk("busy_after_grant", 64'(busy), 64'd1);
                    chk_next = 1'b0;
                end
                if (req_ready != '0) chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                if ((req_valid & req_ready) != '0) begin
                    g = oh_idx(req_valid & req_ready);
                    if (exp_grant_q.size() == 0) begin
                        fail_now("unexpected_grant", $sformatf("grant %0d, none expected", g));
                    end else begin
                        e = exp_grant_q.pop_front();
                        chk("grant_idx", 64'(g), 64'(e));
                        chk_idx  = e;
                        chk_next = 1'b1;
                    end
                    grants_seen++;
                end
                if (req_done != '0) begin
                    if (exp_done_q.size() == 0) begin
                        fail_now("unexpected_done", $sformatf("done %0h, none expected", req_done));
                    end else begin
                        e = exp_done_q.pop_front();
                        chk("done_vec", 64'(req_done), 64'(1) << e);
                    end
                    dones_seen++;
                end
                if (start_txn) begin
                    start_run++;
                end else if (start_run != 0) begin
                    last_start_w = start_run;
                    start_run    = 0;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_done"}, 64'(req_done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_start"}, 64'(start_txn), 64'd0);
        chk({tag, "_rcp_ip"}, 64'(rcp_ip), 64'd0);
        chk({tag, "_rcp_mac"}, 64'(rcp_mac), 64'd0);
        chk({tag, "_rcp_msg"}, 64'(rcp_msg), 64'd0);
`ifdef IP_TX_ARB_STATS_EN
        chk({tag, "_tx_count"}, 64'(tx_count), 64'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_grant_q.delete();
        exp_done_q.delete();
        #1 chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Raise valid on requester i and drop it right after its handshake.
    task automatic issue(input int i);
        bit got;
        got = 1'b0;
        exp_grant_q.push_back(i);
        exp_done_q.push_back(i);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("grant_timeout", $sformatf("requester %0d never granted", i));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_dones(input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            if (dones_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("done_timeout", $sformatf("dones %0d, need %0d", dones_seen, target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int t0;
        bit ok;
        for (int i = 0; i < N; i++) begin
            d_ip[i]  = '0;
            d_mac[i] = '0;
            d_msg[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("init_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single requester, ready same cycle, start next cycle.
        d_ip[0]  = 32'hdeadbeef;
        d_mac[0] = 48'h32dabbadebd5;
        d_msg[0] = 10'h1ff;
        t0 = eng_txns;
        exp_grant_q.push_back(0);
        exp_done_q.push_back(0);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("t1_ready_same_cycle", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_dones(1);
        chk("t1_engine_txns", 64'(eng_txns - t0), 64'd1);

        // 2: both held valid -> 0,1,0,1,0,1.
        do_reset();
        d_ip[0]  = 32'h0a000001; d_mac[0] = 48'h111111111111; d_msg[0] = 10'h011;
        d_ip[1]  = 32'h0a000002; d_mac[1] = 48'h222222222222; d_msg[1] = 10'h322;
        d0 = dones_seen;
        t0 = grants_seen;
        for (int k = 0; k < 6; k++) begin
            exp_grant_q.push_back(k % 2);
            exp_done_q.push_back(k % 2);
        end
        req_valid = 2'b11;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            if (grants_seen >= t0 + 6) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("t2_grant_timeout", $sformatf("grants %0d", grants_seen - t0));
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_dones(d0 + 6);

        // 3: engine shows not-ready in IDLE -> no grant until released.
        d0 = dones_seen;
        force_low = 1'b1;
        exp_grant_q.push_back(1);
        exp_done_q.push_back(1);
        req_valid[1] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t3_no_grant", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 force_low = 1'b0;
        @(negedge clk);
        chk("t3_grant_on_release", 64'(req_ready), 64'b10);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_dones(d0 + 1);

        // 4: slow engine accept -> start held 5 cycles, one transaction.
        eng_lat = 4;
        d0 = dones_seen;
        t0 = eng_txns;
        d_ip[0] = 32'hc0a80105; d_mac[0] = 48'habcdef012345; d_msg[0] = 10'h2a5;
        issue(0);
        wait_dones(d0 + 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_start_width", 64'(last_start_w), 64'd5);
        chk("t4_engine_txns", 64'(eng_txns - t0), 64'd1);
        chk("t4_single_done", 64'(dones_seen - d0), 64'd1);
        eng_lat = 1;

        // 5: reset in WAIT_DONE clears everything at once.
        exp_grant_q.push_back(0);
        exp_done_q.push_back(0);
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy && !start_txn && !eng_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("t5_wait_done_timeout", "never reached WAIT_DONE");
        #2 rst_n = 1'b0;
        exp_done_q.delete();
        #1 chk_reset_outputs("t5_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = dones_seen;
        issue(1);
        wait_dones(d0 + 1);

`ifdef IP_TX_ARB_STATS_EN
        // 6: two-bit counters saturate at 3.
        do_reset();
        d0 = dones_seen;
        for (int k = 0; k < 3; k++) begin
            issue(1);
            wait_dones(d0 + k + 1);
        end
        chk("t6_count1_three", 64'(tx_count[SW +: SW]), 64'd3);
        for (int k = 0; k < 2; k++) begin
            issue(1);
            wait_dones(d0 + k + 4);
        end
        chk("t6_count1_saturated", 64'(tx_count[SW +: SW]), 64'd3);
        chk("t6_count0_zero", 64'(tx_count[0 +: SW]), 64'd0);
`endif

        repeat (3) @(posedge clk);
        chk("final_queues_empty", 64'(exp_grant_q.size() + exp_done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
